div_issue: RTL and testbench

DIV_ISSUE -- requirements
Module: div_issue

---
 rtl/div_issue.sv | 117 +++++++++++
 tb/tb_div_issue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_issue.sv
// Issue stage for a downstream combinational divider.
// Operand pairs go into a 2-entry queue. The head pair drives the divider.
// The quotient, or a divide-by-zero marker, is then registered for the consumer.
module div_issue #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_a,
   input  logic [DATAWIDTH-1:0] in_b,
   output logic [DATAWIDTH-1:0] div_a,
   output logic [DATAWIDTH-1:0] div_b,
   input  logic [DATAWIDTH-1:0] div_quot,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_quot,
   output logic                 out_dbz,
   output logic [1:0]           count
);

   logic [DATAWIDTH-1:0] fifoA_q [2];
   logic [DATAWIDTH-1:0] fifoB_q [2];
   logic                 rdPtr_q, rdPtr_d;
   logic                 wrPtr_q, wrPtr_d;
   logic [1:0]           count_q, count_d;
   logic                 outValid_q, outValid_d;
   logic [DATAWIDTH-1:0] outQuot_q, outQuot_d;
   logic                 outDbz_q, outDbz_d;
   logic                 push;
   logic                 load;
   logic [DATAWIDTH-1:0] headA;
   logic [DATAWIDTH-1:0] headB;

   assign headA = fifoA_q[rdPtr_q];
   assign headB = fifoB_q[rdPtr_q];

   // in_ready uses registered occupancy only, so a pop in the same cycle does not free a slot
   assign in_ready  = (count_q != 2'd2);
   assign push      = in_valid && in_ready;
   assign load      = (count_q != 2'd0) && (!outValid_q || out_ready);

   assign out_valid = outValid_q;
   assign out_quot  = outQuot_q;
   assign out_dbz   = outDbz_q;
   assign count     = count_q;

   // When the queue is idle the divider sees 0/1, so it never gets a zero divisor
   always_comb begin
      div_a = '0;
      div_b = DATAWIDTH'(1);
      if (count_q != 2'd0) begin
         div_a = headA;
         div_b = headB;
      end
   end

   // Next-state logic for the queue pointers, the occupancy, and the result register
   always_comb begin
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q;
      outValid_d = outValid_q;
      outQuot_d  = outQuot_q;
      outDbz_d   = outDbz_q;
      if (push) begin
         wrPtr_d = ~wrPtr_q;
      end
      if (load) begin
         rdPtr_d    = ~rdPtr_q;
         outValid_d = 1'b1;
         if (headB == '0) begin
            outQuot_d = '1;
            outDbz_d  = 1'b1;
         end else begin
            outQuot_d = div_quot;
            outDbz_d  = 1'b0;
         end
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
      unique case ({push, load})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Control and result state; reset clears everything at once, without waiting for a clock edge
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rdPtr_q    <= 1'b0;
         wrPtr_q    <= 1'b0;
         count_q    <= 2'd0;
         outValid_q <= 1'b0;
         outQuot_q  <= '0;
         outDbz_q   <= 1'b0;
      end else begin
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         outValid_q <= outValid_d;
         outQuot_q  <= outQuot_d;
         outDbz_q   <= outDbz_d;
      end
   end

   // Operand storage is only read when count shows it is occupied, so it needs no reset
   always_ff @(posedge Clk) begin
      if (push) begin
         fifoA_q[wrPtr_q] <= in_a;
         fifoB_q[wrPtr_q] <= in_b;
      end
   end

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue.
// A queue-based reference model predicts every output on every cycle.
// A table of known quotients covers the boundary operands.
module tb_div_issue;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [7:0] div_a;
   logic [7:0] div_b;
   logic [7:0] div_quot;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_quot;
   logic       out_dbz;
   logic [1:0] count;

   int checks = 0;
   int errors = 0;

   // Reference model: queued pairs, result register contents
   logic [15:0] mq[$];
   bit          mValid;
   logic [7:0]  mQuot;
   bit          mDbz;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic       dbz;
   } vec_t;
   vec_t vecs[7];

   div_issue #(.DATAWIDTH(8)) dut (
      .Clk(Clk), .Rst(Rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .div_a(div_a), .div_b(div_b), .div_quot(div_quot),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quot(out_quot), .out_dbz(out_dbz), .count(count)
   );

   // Behavioural combinational divider standing in for the downstream unit
   assign div_quot = (div_b == 8'd0) ? 8'hFF : div_a / div_b;

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".count"}, 32'(count), 32'(mq.size()));
      checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
      checkOutput({tag, ".out_quot"}, 32'(out_quot), 32'(mQuot));
      checkOutput({tag, ".out_dbz"}, 32'(out_dbz), 32'(mDbz));
      if (mq.size() > 0) begin
         checkOutput({tag, ".div_a"}, 32'(div_a), 32'(mq[0][15:8]));
         checkOutput({tag, ".div_b"}, 32'(div_b), 32'(mq[0][7:0]));
      end else begin
         checkOutput({tag, ".div_a_idle"}, 32'(div_a), 32'd0);
         checkOutput({tag, ".div_b_idle"}, 32'(div_b), 32'd1);
      end
   endtask

   task automatic resetModel();
      mq.delete();
      mValid = 0;
      mQuot  = 8'd0;
      mDbz   = 0;
   endtask

   // Advance the model by one edge using the currently applied inputs
   task automatic modelStep();
      bit          acc;
      bit          ld;
      logic [15:0] p;
      acc = in_valid && (mq.size() < 2);
      ld  = (mq.size() > 0) && (!mValid || out_ready);
      if (ld) begin
         p = mq.pop_front();
         mValid = 1;
         if (p[7:0] == 8'd0) begin
            mQuot = 8'hFF;
            mDbz  = 1;
         end else begin
            mQuot = p[15:8] / p[7:0];
            mDbz  = 0;
         end
      end else if (out_ready) begin
         mValid = 0;
      end
      if (acc) mq.push_back({in_a, in_b});
   endtask

   // Drive inputs, step model, clock once, then compare 1 time unit after the edge
   task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                input logic r, input string tag);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      out_ready = r;
      modelStep();
      @(posedge Clk);
      #1;
      checkState(tag);
   endtask

   initial begin
      vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  dbz: 1'b0};
      vecs[1] = '{a: 8'd55,  b: 8'd0,   q: 8'hFF,  dbz: 1'b1};
      vecs[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, dbz: 1'b0};
      vecs[3] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   dbz: 1'b0};
      vecs[4] = '{a: 8'd7,   b: 8'd255, q: 8'd0,   dbz: 1'b0};
      vecs[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   dbz: 1'b0};
      vecs[6] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  dbz: 1'b1};

      in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
      Rst = 1;
      resetModel();
      #3;
      checkState("reset");
      @(negedge Clk);
      @(negedge Clk);
      Rst = 0;

      // Single operations from the table: latency, result value, then drain
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1, vecs[i].a, vecs[i].b, 1, "vecPush");
         checkOutput("vecNotYetValid", 32'(out_valid), 32'd0);
         applyStimulus(0, 8'd0, 8'd0, 1, "vecLoad");
         checkOutput("vecQuot", 32'(out_quot), 32'(vecs[i].q));
         checkOutput("vecDbz", 32'(out_dbz), 32'(vecs[i].dbz));
         checkOutput("vecValid", 32'(out_valid), 32'd1);
         applyStimulus(0, 8'd0, 8'd0, 1, "vecDrain");
         checkOutput("vecCleared", 32'(out_valid), 32'd0);
      end

      // Backpressure: the first result is held, the queue fills, and a fourth pair is refused
      applyStimulus(1, 8'd20, 8'd4, 0, "bp1");
      applyStimulus(1, 8'd9,  8'd3, 0, "bp2");
      checkOutput("bpHeld5", 32'(out_quot), 32'd5);
      applyStimulus(1, 8'd8,  8'd2, 0, "bp3");
      checkOutput("bpCount2", 32'(count), 32'd2);
      checkOutput("bpNotReady", 32'(in_ready), 32'd0);
      applyStimulus(1, 8'd1,  8'd1, 0, "bpRefused");
      checkOutput("bpStill5", 32'(out_quot), 32'd5);
      applyStimulus(0, 8'd0, 8'd0, 1, "bpDrain1");
      checkOutput("bpResult3", 32'(out_quot), 32'd3);
      applyStimulus(0, 8'd0, 8'd0, 1, "bpDrain2");
      checkOutput("bpResult4", 32'(out_quot), 32'd4);
      applyStimulus(0, 8'd0, 8'd0, 1, "bpDrain3");
      applyStimulus(0, 8'd0, 8'd0, 1, "bpIdle");

      // Streaming: back-to-back pairs with a ready consumer; occupancy stays at most 1
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 8'($urandom), 8'($urandom_range(0, 20)), 1, "stream");
         checkOutput("streamCountLe1", 32'(count <= 2'd1), 32'd1);
      end
      applyStimulus(0, 8'd0, 8'd0, 1, "streamTail");
      applyStimulus(0, 8'd0, 8'd0, 1, "streamIdle");

      // Reset mid-stream with a full queue and a held result
      applyStimulus(1, 8'd40, 8'd5, 0, "rs1");
      applyStimulus(1, 8'd30, 8'd6, 0, "rs2");
      applyStimulus(1, 8'd21, 8'd7, 0, "rs3");
      checkOutput("rsFull", 32'(count), 32'd2);
      #2;
      Rst = 1;
      #1;
      resetModel();
      checkState("rsAsync");
      @(negedge Clk);
      Rst = 0;
      applyStimulus(0, 8'd0, 8'd0, 1, "rsIdle");
      applyStimulus(1, 8'd6, 8'd3, 1, "rsPush");
      checkOutput("rsNoStale", 32'(out_valid), 32'd0);
      applyStimulus(0, 8'd0, 8'd0, 1, "rsLoad");
      checkOutput("rsQuot2", 32'(out_quot), 32'd2);

      // Random traffic with random backpressure and occasional zero divisors
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                       ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
                       1'($urandom_range(0, 2) != 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
